coin_settle: RTL and testbench
==============================

COIN_SETTLE -- requirements
Module: coin_settle

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 250000000, dispense duration in clk cycles (5 s at 50 MHz).
REQ-002 Parameter MAX_BAL, default 40, balance ceiling in 0.5-yuan units (20 yuan).
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 coin  input  3  coin level, one-hot: 001 = 0.5 yuan (1 unit), 010 = 1 yuan (2 units), 100 = 5 yuan (10 units), 000 = none.
REQ-006 sel  input  2  drink select; price 0→5, 1→7, 2→10, 3→12 units.
REQ-007 confirm  input  1  buyer purchase button, level.
REQ-008 cancel  input  1  buyer cancel button, level.
REQ-009 press  output  1  one-cycle purchase pulse to the vending state machine.
REQ-010 cancel_flag  output  1  one-cycle cancel pulse to the vending state machine.
REQ-011 timeout  output  1  one-cycle end-of-dispense pulse to the vending state machine.
REQ-012 balance  output  6  accumulated credit, units.
REQ-013 change  output  6  change owed, units.
REQ-014 coin_reject  output  1  one-cycle pulse, coin event refused.
REQ-015 insufficient  output  1  one-cycle pulse, confirm with balance < price.
REQ-016 busy  output  1  high in DISPENSE.

Function
REQ-017 States IDLE, COLLECT, DISPENSE; encoded internally, not exported.
REQ-018 Coin event = coin != 0 in this cycle and coin == 0 in the previous cycle (registered previous sample); held coins count once.
REQ-019 Coin event with a non-one-hot code SHALL pulse coin_reject and leave balance unchanged.
REQ-020 Valid coin event in IDLE/COLLECT: if balance + value <= MAX_BAL, balance updates at the same edge, state → COLLECT; otherwise coin_reject pulses, balance unchanged.
REQ-021 Coin event in DISPENSE SHALL pulse coin_reject.
REQ-022 Confirm and cancel events are rising edges (registered previous samples); levels held high act once.
REQ-023 Confirm edge in COLLECT with balance >= price(sel): press pulses next cycle, change latched = balance − price, balance cleared to 0, state → DISPENSE.
REQ-024 Confirm edge in COLLECT with balance < price: insufficient pulses next cycle, state and balance unchanged.
REQ-025 Cancel edge in COLLECT: cancel_flag pulses next cycle, change latched = balance, balance cleared, state → DISPENSE.
REQ-026 Cancel and confirm edges in the same cycle: cancel wins; no press, no insufficient.
REQ-027 Coin event in the same cycle as an accepted confirm or cancel: coin_reject pulses, coin not credited, change computed from pre-coin balance.
REQ-028 Confirm/cancel edges in IDLE or DISPENSE are ignored (no pulses).
REQ-029 DISPENSE: counter counts from 0; at count TIMEOUT_CYCLES−1 timeout pulses one cycle, change clears to 0, counter clears, state → IDLE at that edge.
REQ-030 sel sampled only on the confirm-edge cycle; later changes have no effect.
REQ-031 balance never exceeds MAX_BAL; all arithmetic 6-bit unsigned, no wrap possible by construction.
REQ-032 All outputs registered; busy = (state == DISPENSE).

Reset
REQ-033 reset high at a clock edge: state IDLE, balance 0, change 0, counter 0, edge-detect registers 0, all pulse outputs 0, busy 0.
REQ-034 Reset mid-DISPENSE or mid-COLLECT discards credit and pending pulses; no timeout generated.
REQ-035 Coin/confirm/cancel held high across reset release do not generate events until they return to 0 and rise again.

Verification (TIMEOUT_CYCLES = 8)
REQ-036 Coins 010, 100, 001 (each 3 cycles, gaps of 0) → balance 2, 12, 13; no coin_reject.
REQ-037 Balance 13, sel=2, confirm edge → press one cycle later, change 3, balance 0, busy; timeout exactly 8 cycles after DISPENSE entry, then change 0, IDLE.
REQ-038 Balance 4, sel=1, confirm → insufficient pulse, balance 4, state COLLECT; then cancel → cancel_flag, change 4.
REQ-039 Balance 35, coin 100 → coin_reject, balance 35; coin 011 → coin_reject.
REQ-040 Balance 12, confirm and cancel same cycle with coin 001 → cancel_flag only, change 12, coin_reject.
REQ-041 reset asserted 3 cycles into DISPENSE → all outputs 0 next cycle, no timeout afterwards.

Source files
------------

// File: rtl/coin_settle.sv
// Coin acceptor and settlement front end: credits coins, settles purchase or
// cancel requests, and times the dispense window for the vending state machine.
module coin_settle #(
   parameter int unsigned TIMEOUT_CYCLES = 250000000,
   parameter int unsigned MAX_BAL        = 40
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] coin,
   input  logic [1:0] sel,
   input  logic       confirm,
   input  logic       cancel,
   output logic       press,
   output logic       cancel_flag,
   output logic       timeout,
   output logic [5:0] balance,
   output logic [5:0] change,
   output logic       coin_reject,
   output logic       insufficient,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE} state_t;

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [5:0] MAX_B = 6'(MAX_BAL);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [5:0]       balance_n, change_n;
   logic             press_n, cancel_flag_n, timeout_n, coin_reject_n, insufficient_n;

   logic [2:0] coin_prev;
   logic       confirm_prev, cancel_prev;
   // An input only becomes armed after it has been seen low outside reset, so
   // a level held across reset release cannot masquerade as a fresh edge.
   logic       coin_armed, confirm_armed, cancel_armed;

   logic       coin_ev, confirm_ev, cancel_ev;
   logic       coin_ok, settle;
   logic [5:0] coin_val, price;

   assign coin_ev    = (coin != 3'b000) && (coin_prev == 3'b000) && coin_armed;
   assign confirm_ev = confirm && !confirm_prev && confirm_armed;
   assign cancel_ev  = cancel && !cancel_prev && cancel_armed;

   always_comb begin
      coin_ok  = 1'b1;
      coin_val = 6'd0;
      case (coin)
         3'b001:  coin_val = 6'd1;
         3'b010:  coin_val = 6'd2;
         3'b100:  coin_val = 6'd10;
         default: coin_ok  = 1'b0;
      endcase
   end

   always_comb begin
      case (sel)
         2'd0:    price = 6'd5;
         2'd1:    price = 6'd7;
         2'd2:    price = 6'd10;
         default: price = 6'd12;
      endcase
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_n        = state;
      cnt_n          = cnt;
      balance_n      = balance;
      change_n       = change;
      press_n        = 1'b0;
      cancel_flag_n  = 1'b0;
      timeout_n      = 1'b0;
      coin_reject_n  = 1'b0;
      insufficient_n = 1'b0;
      settle         = 1'b0;

      case (state)
         IDLE: ;
         COLLECT: begin
            if (cancel_ev) begin
               cancel_flag_n = 1'b1;
               change_n      = balance;
               balance_n     = 6'd0;
               cnt_n         = '0;
               state_n       = DISPENSE;
               settle        = 1'b1;
            end else if (confirm_ev) begin
               if (balance >= price) begin
                  press_n   = 1'b1;
                  change_n  = balance - price;
                  balance_n = 6'd0;
                  cnt_n     = '0;
                  state_n   = DISPENSE;
                  settle    = 1'b1;
               end else begin
                  insufficient_n = 1'b1;
               end
            end
         end
         DISPENSE: begin
            if (cnt == CNT_LAST) begin
               timeout_n = 1'b1;
               change_n  = 6'd0;
               cnt_n     = '0;
               state_n   = IDLE;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      // A coin arriving with a settlement is refused so change uses the old balance.
      if (coin_ev) begin
         if (state == DISPENSE || settle || !coin_ok || (balance + coin_val) > MAX_B) begin
            coin_reject_n = 1'b1;
         end else begin
            balance_n = balance + coin_val;
            state_n   = COLLECT;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         balance       <= 6'd0;
         change        <= 6'd0;
         press         <= 1'b0;
         cancel_flag   <= 1'b0;
         timeout       <= 1'b0;
         coin_reject   <= 1'b0;
         insufficient  <= 1'b0;
         busy          <= 1'b0;
         coin_prev     <= 3'b000;
         confirm_prev  <= 1'b0;
         cancel_prev   <= 1'b0;
         coin_armed    <= 1'b0;
         confirm_armed <= 1'b0;
         cancel_armed  <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         balance       <= balance_n;
         change        <= change_n;
         press         <= press_n;
         cancel_flag   <= cancel_flag_n;
         timeout       <= timeout_n;
         coin_reject   <= coin_reject_n;
         insufficient  <= insufficient_n;
         busy          <= (state_n == DISPENSE);
         coin_prev     <= coin;
         confirm_prev  <= confirm;
         cancel_prev   <= cancel;
         coin_armed    <= coin_armed | (coin == 3'b000);
         confirm_armed <= confirm_armed | !confirm;
         cancel_armed  <= cancel_armed | !cancel;
      end
   end

endmodule

// File: tb/tb_coin_settle.sv
// Directed scenarios followed by random traffic, every cycle compared against a
// transaction-level model of credit, settlement and the dispense window.
module tb_coin_settle;

   localparam int T    = 8;
   localparam int MAXB = 40;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] coin;
   logic [1:0] sel;
   logic       confirm, cancel;
   logic       press, cancel_flag, timeout, coin_reject, insufficient, busy;
   logic [5:0] balance, change;

   int checks = 0;
   int errors = 0;

   coin_settle #(.TIMEOUT_CYCLES(T), .MAX_BAL(MAXB)) dut (
      .clk(clk), .reset(reset), .coin(coin), .sel(sel), .confirm(confirm),
      .cancel(cancel), .press(press), .cancel_flag(cancel_flag), .timeout(timeout),
      .balance(balance), .change(change), .coin_reject(coin_reject),
      .insufficient(insufficient), .busy(busy)
   );

   always #5 clk = ~clk;

   // Model: phase 0 = waiting, 1 = holding credit, 2 = dispensing (m_left edges to go)
   int   m_phase, m_left, m_bal, m_chg;
   bit   m_press, m_cflag, m_tmo, m_rej, m_ins;
   int   m_coin_prev;
   bit   m_conf_prev, m_canc_prev, m_coin_low, m_conf_low, m_canc_low;

   function automatic int coin_units(int c);
      case (c)
         1:       return 1;
         2:       return 2;
         4:       return 10;
         default: return 0;
      endcase
   endfunction

   function automatic int price_of(int s);
      int p[4] = '{5, 7, 10, 12};
      return p[s];
   endfunction

   task automatic model_edge();
      bit coin_ev, conf_ev, canc_ev, settled;
      int old_phase, old_bal, v;
      m_press = 0; m_cflag = 0; m_tmo = 0; m_rej = 0; m_ins = 0;
      if (reset) begin
         m_phase = 0; m_left = 0; m_bal = 0; m_chg = 0;
         m_coin_prev = 0; m_conf_prev = 0; m_canc_prev = 0;
         m_coin_low = 0; m_conf_low = 0; m_canc_low = 0;
         return;
      end
      coin_ev   = (int'(coin) != 0) && (m_coin_prev == 0) && m_coin_low;
      conf_ev   = confirm && !m_conf_prev && m_conf_low;
      canc_ev   = cancel && !m_canc_prev && m_canc_low;
      old_phase = m_phase;
      old_bal   = m_bal;
      settled   = 0;
      if (old_phase == 2) begin
         m_left--;
         if (m_left == 0) begin
            m_tmo = 1; m_chg = 0; m_phase = 0;
         end
      end
      if (old_phase == 1 && canc_ev) begin
         m_cflag = 1; m_chg = old_bal; m_bal = 0; m_phase = 2; m_left = T; settled = 1;
      end else if (old_phase == 1 && conf_ev) begin
         if (old_bal >= price_of(int'(sel))) begin
            m_press = 1; m_chg = old_bal - price_of(int'(sel)); m_bal = 0;
            m_phase = 2; m_left = T; settled = 1;
         end else begin
            m_ins = 1;
         end
      end
      if (coin_ev) begin
         v = coin_units(int'(coin));
         if (old_phase == 2 || settled || v == 0 || old_bal + v > MAXB) m_rej = 1;
         else begin
            m_bal = old_bal + v; m_phase = 1;
         end
      end
      if (coin == 3'b000) m_coin_low = 1;
      if (!confirm) m_conf_low = 1;
      if (!cancel) m_canc_low = 1;
      m_coin_prev = int'(coin);
      m_conf_prev = confirm;
      m_canc_prev = cancel;
   endtask

   task automatic compare();
      checks += 9;
      assert (press === m_press) else begin
         errors++; $error("FAIL press: got %0b expected %0b", press, m_press);
      end
      assert (cancel_flag === m_cflag) else begin
         errors++; $error("FAIL cancel_flag: got %0b expected %0b", cancel_flag, m_cflag);
      end
      assert (timeout === m_tmo) else begin
         errors++; $error("FAIL timeout: got %0b expected %0b", timeout, m_tmo);
      end
      assert (coin_reject === m_rej) else begin
         errors++; $error("FAIL coin_reject: got %0b expected %0b", coin_reject, m_rej);
      end
      assert (insufficient === m_ins) else begin
         errors++; $error("FAIL insufficient: got %0b expected %0b", insufficient, m_ins);
      end
      assert (balance === 6'(m_bal)) else begin
         errors++; $error("FAIL balance: got %0d expected %0d", balance, m_bal);
      end
      assert (change === 6'(m_chg)) else begin
         errors++; $error("FAIL change: got %0d expected %0d", change, m_chg);
      end
      assert (busy === (m_phase == 2)) else begin
         errors++; $error("FAIL busy: got %0b expected %0b", busy, (m_phase == 2));
      end
      assert (!$isunknown({balance, change})) else begin
         errors++; $error("FAIL unknown: got %h %h expected known", balance, change);
      end
   endtask

   task automatic expect_eq(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++; $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic drive(input logic [2:0] c, input logic [1:0] s, input bit cf,
                        input bit cn, input bit r, input int n);
      coin = c; sel = s; confirm = cf; cancel = cn; reset = r;
      repeat (n) step();
   endtask

   task automatic insert(input logic [2:0] c);
      drive(c, 2'd0, 0, 0, 0, 3);
      drive(3'b000, 2'd0, 0, 0, 0, 1);
   endtask

   initial begin
      coin = 3'b000; sel = 2'd0; confirm = 0; cancel = 0; reset = 1;
      // Reset with a coin held high through release
      drive(3'b010, 2'd0, 0, 0, 1, 2);
      expect_eq("reset_balance", int'(balance), 0);
      drive(3'b010, 2'd0, 0, 0, 0, 3);
      expect_eq("held_coin_ignored", int'(balance), 0);
      drive(3'b000, 2'd0, 0, 0, 0, 1);

      // Coin sequence 2, 10, 1
      insert(3'b010);
      expect_eq("bal_after_1yuan", int'(balance), 2);
      insert(3'b100);
      insert(3'b001);
      expect_eq("bal_13", int'(balance), 13);

      // Purchase price 10 and dispense window
      drive(3'b000, 2'd2, 1, 0, 0, 1);
      expect_eq("press", int'(press), 1);
      expect_eq("change_3", int'(change), 3);
      expect_eq("busy_dispense", int'(busy), 1);
      drive(3'b000, 2'd3, 0, 0, 0, 7);
      expect_eq("no_early_timeout", int'(timeout), 0);
      drive(3'b000, 2'd3, 0, 0, 0, 1);
      expect_eq("timeout_at_8", int'(timeout), 1);
      expect_eq("change_cleared", int'(change), 0);

      // Insufficient then cancel
      insert(3'b010);
      insert(3'b010);
      drive(3'b000, 2'd1, 1, 0, 0, 1);
      expect_eq("insufficient", int'(insufficient), 1);
      expect_eq("bal_kept_4", int'(balance), 4);
      drive(3'b000, 2'd1, 0, 0, 0, 1);
      drive(3'b000, 2'd1, 0, 1, 0, 1);
      expect_eq("cancel_flag", int'(cancel_flag), 1);
      expect_eq("cancel_change_4", int'(change), 4);
      drive(3'b000, 2'd0, 0, 0, 0, T + 1);

      // Ceiling and malformed coin
      insert(3'b100); insert(3'b100); insert(3'b100);
      insert(3'b010); insert(3'b010); insert(3'b001);
      expect_eq("bal_35", int'(balance), 35);
      drive(3'b100, 2'd0, 0, 0, 0, 1);
      expect_eq("overflow_reject", int'(coin_reject), 1);
      drive(3'b000, 2'd0, 0, 0, 0, 1);
      drive(3'b011, 2'd0, 0, 0, 0, 1);
      expect_eq("bad_code_reject", int'(coin_reject), 1);
      expect_eq("bal_still_35", int'(balance), 35);
      drive(3'b000, 2'd0, 0, 1, 0, 1);
      drive(3'b000, 2'd0, 0, 0, 0, T + 1);

      // Confirm, cancel and coin together
      insert(3'b100); insert(3'b010);
      drive(3'b001, 2'd0, 1, 1, 0, 1);
      expect_eq("both_cancel_flag", int'(cancel_flag), 1);
      expect_eq("both_no_press", int'(press), 0);
      expect_eq("both_change_12", int'(change), 12);
      expect_eq("both_coin_reject", int'(coin_reject), 1);
      drive(3'b000, 2'd0, 0, 0, 0, T + 1);

      // Reset in the middle of dispense
      insert(3'b100);
      drive(3'b000, 2'd0, 1, 0, 0, 1);
      drive(3'b000, 2'd0, 0, 0, 0, 2);
      drive(3'b000, 2'd0, 0, 0, 1, 1);
      expect_eq("reset_busy", int'(busy), 0);
      expect_eq("reset_change", int'(change), 0);
      drive(3'b000, 2'd0, 0, 0, 0, 2 * T);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         int r;
         if ($urandom_range(0, 1) == 1) begin
            r = int'($urandom_range(0, 99));
            if (r < 50)      coin = 3'b000;
            else if (r < 65) coin = 3'b001;
            else if (r < 78) coin = 3'b010;
            else if (r < 92) coin = 3'b100;
            else             coin = 3'($urandom_range(3, 7));
         end
         sel     = 2'($urandom_range(0, 3));
         confirm = ($urandom_range(0, 7) == 0);
         cancel  = ($urandom_range(0, 29) == 0);
         reset   = ($urandom_range(0, 299) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
